// File: rtl/dm_ram_be.sv
// dm_ram_be: parametrised byte-addressable data memory with byte/half/word access and sign/zero extension.
// Latency: stores commit at the accepting edge; loads return M_R_Data/M_R_Valid registered at the accepting edge.
// Backpressure: Mem_Ready is low for the DEPTH-cycle post-reset clear sweep; afterwards one access is accepted every cycle.
//
// Ports:
//   clk_dm        memory clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   Mem_Req       access request, only taken while Mem_Ready=1
//   Mem_Write     1=store, 0=load
//   Mem_Size      00=byte, 01=half, 10=word, 11=illegal
//   Mem_Unsigned  loads: 1=zero-extend, 0=sign-extend
//   DM_Addr       byte address (word index = [ADDR_W-1:2], lane = [1:0], little-endian)
//   M_W_Data      store data, low bytes used for byte/half stores
//   Mem_Ready     block accepts a request this cycle
//   M_R_Data      extended load result, held until the next load completes
//   M_R_Valid     one-cycle strobe, M_R_Data is new
//   Mem_Misalign  one-cycle strobe, the accepted request was misaligned or illegal
module dm_ram_be #(
    parameter int          DEPTH   = 64,
    parameter int          ADDR_W  = 8,
    parameter logic [31:0] CLR_VAL = 32'h0000_0000
) (
    input  logic              clk_dm,
    input  logic              rst_n,
    input  logic              Mem_Req,
    input  logic              Mem_Write,
    input  logic [1:0]        Mem_Size,
    input  logic              Mem_Unsigned,
    input  logic [ADDR_W-1:0] DM_Addr,
    input  logic [31:0]       M_W_Data,
    output logic              Mem_Ready,
    output logic [31:0]       M_R_Data,
    output logic              M_R_Valid,
    output logic              Mem_Misalign
);

    // DEPTH must be a power of two and ADDR_W = log2(DEPTH)+2.
    localparam int IDX_W = ADDR_W - 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvld_q, rvld_d;
    logic             mis_q, mis_d;

    // Storage array: deliberately not reset, the clear sweep defines it.
    logic [31:0]      mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] widx;
    logic [1:0]       lane;
    logic             accept;
    logic             misalign;
    logic             do_st;
    logic             do_ld;
    logic             clr_we;

    assign widx   = DM_Addr[ADDR_W-1:2];
    assign lane   = DM_Addr[1:0];
    assign accept = Mem_Req && (state_q == ST_IDLE);

    always_comb begin
        misalign = 1'b0;
        case (Mem_Size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = lane[0];
            2'b10:   misalign = |lane;
            default: misalign = 1'b1;
        endcase
    end

    assign do_st  = accept && !misalign && Mem_Write;
    assign do_ld  = accept && !misalign && !Mem_Write;
    // While rst_n is low this keeps rewriting word 0 with CLR_VAL, which
    // the sweep after deassertion does anyway, so it is harmless.
    assign clr_we = (state_q == ST_CLEAR);

    // ------------------------------------------------------------------
    // Store lane enables and lane-replicated write data
    // ------------------------------------------------------------------
    logic [3:0]  be;
    logic [31:0] wdat;

    always_comb begin
        be   = 4'b0000;
        wdat = M_W_Data;
        case (Mem_Size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wdat = {4{M_W_Data[7:0]}};
            end
            2'b01: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wdat = {2{M_W_Data[15:0]}};
            end
            2'b10: begin
                be   = 4'b1111;
                wdat = M_W_Data;
            end
            default: begin
                be   = 4'b0000;
                wdat = M_W_Data;
            end
        endcase
    end

    always_ff @(posedge clk_dm) begin
        if (clr_we) begin
            mem_q[cnt_q] <= CLR_VAL;
        end else if (do_st) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[widx][b*8 +: 8] <= wdat[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------
    logic [31:0] rword;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ld_ext;

    assign rword = mem_q[widx];

    always_comb begin
        bsel   = rword[{lane, 3'b000} +: 8];
        hsel   = lane[1] ? rword[31:16] : rword[15:0];
        ld_ext = rword;
        case (Mem_Size)
            2'b00:   ld_ext = {{24{bsel[7] & ~Mem_Unsigned}}, bsel};
            2'b01:   ld_ext = {{16{hsel[15] & ~Mem_Unsigned}}, hsel};
            default: ld_ext = rword;
        endcase
    end

    // ------------------------------------------------------------------
    // Control next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rvld_d  = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ONE_IDX;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (do_ld) begin
                    rdata_d = ld_ext;
                    rvld_d  = 1'b1;
                end
                mis_d = accept && misalign;
            end
        endcase
    end

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            rdata_q <= '0;
            rvld_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
            mis_q   <= mis_d;
        end
    end

    // Mem_Ready is decoded from the reset-cleared state so it also drops
    // asynchronously with rst_n.
    assign Mem_Ready    = (state_q == ST_IDLE);
    assign M_R_Data     = rdata_q;
    assign M_R_Valid    = rvld_q;
    assign Mem_Misalign = mis_q;

endmodule
